vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA raster counters with registered sync/draw/position decodes.
//            Optional 8-bit frame counter when VGA_FRAME_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       pixelclock,
  input  logic       resetn,
  input  logic       en,
  output logic       hsinc,
  output logic       vsinc,
  output logic       draw,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsinc;
  logic       r_vsinc;
  logic       r_draw;
  logic [9:0] r_h_pos;
  logic [9:0] r_v_pos;
  logic       r_frame_start;

  logic w_h_last;
  logic w_v_last;
  logic w_hsinc;
  logic w_vsinc;
  logic w_draw;
  logic w_frame_start;

  assign w_h_last      = (r_h_cnt == c_H_LAST);
  assign w_v_last      = (r_v_cnt == c_V_LAST);
  assign w_hsinc       = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
  assign w_vsinc       = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));
  assign w_draw        = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
  assign w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  always_ff @(posedge pixelclock or negedge resetn) begin
    if (!resetn) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (en) begin
      r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_last) begin
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end
    end
  end

  // Outputs decode the counter value present before this edge's advance,
  // so they lag the counters by exactly one enabled clock.
  always_ff @(posedge pixelclock or negedge resetn) begin
    if (!resetn) begin
      r_hsinc       <= 1'b1;
      r_vsinc       <= 1'b1;
      r_draw        <= 1'b0;
      r_h_pos       <= 10'd0;
      r_v_pos       <= 10'd0;
      r_frame_start <= 1'b0;
    end else if (en) begin
      r_hsinc       <= w_hsinc;
      r_vsinc       <= w_vsinc;
      r_draw        <= w_draw;
      r_h_pos       <= r_h_cnt;
      r_v_pos       <= r_v_cnt;
      r_frame_start <= w_frame_start;
    end
  end

  assign hsinc       = r_hsinc;
  assign vsinc       = r_vsinc;
  assign draw        = r_draw;
  assign h_pos       = r_h_pos;
  assign v_pos       = r_v_pos;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Advances on the same edge that raises frame_start.
  always_ff @(posedge pixelclock or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= 8'd0;
    end else if (en && w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire
